// File: rtl/regfile_sched_pkg.sv
// regfile_sched_pkg: shared constants and state type for the register file write scheduler
package regfile_sched_pkg;
    localparam int NUM_REGS = 32;
    localparam int ADR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [ADR_W-1:0] CLEAR_LAST = ADR_W'(NUM_REGS - 1);
    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter, the requester not served last wins contention
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    logic last_b_q;
    // Grant a lone requester outright; on contention favour the side not served last
    always_comb grant = {req[1] & (~req[0] | ~last_b_q), req[0] & (~req[1] | last_b_q)};
    // Track which side was served; starting at B lets A win the first contention
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_b_q <= 1'b1;
        else if (accept) last_b_q <= grant[1];
endmodule

// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: clears r1..r31 after reset, then arbitrates the single register file write port
module regfile_wr_sched
    import regfile_sched_pkg::*;
#(
    parameter bit INIT_CLEAR = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              A_Valid,
    input  logic [ADR_W-1:0]  A_Adr,
    input  logic [DATA_W-1:0] A_Data,
    output logic              A_Ready,
    input  logic              B_Valid,
    input  logic [ADR_W-1:0]  B_Adr,
    input  logic [DATA_W-1:0] B_Data,
    output logic              B_Ready,
    output logic [ADR_W-1:0]  Awr,
    output logic [DATA_W-1:0] Din,
    output logic              WrEn,
    output logic              InitDone,
    output logic [CNT_W-1:0]  WrCount
);
    state_e state_q, state_d;
    logic [ADR_W-1:0] cnt_q, cnt_d, awr_q, awr_d, sel_adr;
    logic [DATA_W-1:0] din_q, din_d, sel_data;
    logic wr_en_q, wr_en_d, done_q, init, xfer;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;
    logic [1:0] req, grant;

    rr_arb2 u_arb (
        .clk    (Clk),
        .rst_n  (Reset),
        .req    (req),
        .accept (xfer),
        .grant  (grant)
    );

    // Next-state: clear sweep in INIT, winner's write (r0 filtered) in RUN; Reset gates Ready
    always_comb begin
        init = state_q == INIT;
        req = {B_Valid, A_Valid} & {2{Reset & (state_q == RUN)}};
        xfer = |grant;
        sel_adr = grant[1] ? B_Adr : A_Adr;
        sel_data = grant[1] ? B_Data : A_Data;
        state_d = (init && cnt_q == CLEAR_LAST) ? RUN : state_q;
        cnt_d = init ? cnt_q + ADR_W'(1) : cnt_q;
        wr_en_d = init | (xfer & |sel_adr);
        awr_d = init ? cnt_q : xfer ? sel_adr : awr_q;
        din_d = init ? '0 : xfer ? sel_data : din_q;
        wr_count_d = (wr_en_q & done_q & ~&wr_count_q) ? wr_count_q + CNT_W'(1) : wr_count_q;
    end

    // State, write register stage and counters; done_q lags RUN so the last clear write is not counted
    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) begin
            state_q <= INIT_CLEAR ? INIT : RUN;
            cnt_q <= ADR_W'(1);
            wr_en_q <= 1'b0;
            awr_q <= '0;
            din_q <= '0;
            done_q <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            wr_en_q <= wr_en_d;
            awr_q <= awr_d;
            din_q <= din_d;
            done_q <= done_q | (state_q == RUN);
            wr_count_q <= wr_count_d;
        end

    assign A_Ready = grant[0];
    assign B_Ready = grant[1];
    assign Awr = awr_q;
    assign Din = din_q;
    assign WrEn = wr_en_q;
    assign InitDone = done_q;
    assign WrCount = wr_count_q;
endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb_regfile_wr_sched: scoreboard bench for the write scheduler with and without the reset clear
module tb_regfile_wr_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n, a0_valid, b0_valid, a0_ready, b0_ready, wren0, done0;
    logic [4:0] a0_adr, b0_adr, awr0;
    logic [31:0] a0_data, b0_data, din0;
    logic [15:0] cnt0;
    logic rst1_n, a1_valid, b1_valid, a1_ready, b1_ready, wren1, done1;
    logic [4:0] a1_adr, b1_adr, awr1;
    logic [31:0] a1_data, b1_data, din1;
    logic [15:0] cnt1;

    int checks = 0;
    int failures = 0;
    logic [36:0] q0[$];
    logic [36:0] q1[$];

    regfile_wr_sched #(.INIT_CLEAR(1'b1), .CNT_W(16)) u0 (
        .Clk(clk), .Reset(rst0_n),
        .A_Valid(a0_valid), .A_Adr(a0_adr), .A_Data(a0_data), .A_Ready(a0_ready),
        .B_Valid(b0_valid), .B_Adr(b0_adr), .B_Data(b0_data), .B_Ready(b0_ready),
        .Awr(awr0), .Din(din0), .WrEn(wren0), .InitDone(done0), .WrCount(cnt0)
    );

    regfile_wr_sched #(.INIT_CLEAR(1'b0), .CNT_W(16)) u1 (
        .Clk(clk), .Reset(rst1_n),
        .A_Valid(a1_valid), .A_Adr(a1_adr), .A_Data(a1_data), .A_Ready(a1_ready),
        .B_Valid(b1_valid), .B_Adr(b1_adr), .B_Data(b1_data), .B_Ready(b1_ready),
        .Awr(awr1), .Din(din1), .WrEn(wren1), .InitDone(done1), .WrCount(cnt1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Write-port monitors: every WrEn=1 cycle must match the oldest expected write
    always @(negedge clk)
        if (wren0) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr0_unexpected actual=%h/%h required=none", awr0, din0);
            end else begin
                logic [36:0] e;
                e = q0.pop_front();
                check("wr0_awr", 32'(awr0), 32'(e[36:32]));
                check("wr0_din", din0, e[31:0]);
            end
        end

    always @(negedge clk)
        if (wren1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr1_unexpected actual=%h/%h required=none", awr1, din1);
            end else begin
                logic [36:0] e;
                e = q1.pop_front();
                check("wr1_awr", 32'(awr1), 32'(e[36:32]));
                check("wr1_din", din1, e[31:0]);
            end
        end

    logic [3:0] grant_a;

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        a0_valid = 1'b0; a0_adr = '0; a0_data = '0;
        b0_valid = 1'b0; b0_adr = '0; b0_data = '0;
        a1_valid = 1'b1; a1_adr = 5'd12; a1_data = 32'hCAFEF00D;
        b1_valid = 1'b0; b1_adr = '0; b1_data = '0;
        grant_a = 4'b0101;
        tick;
        tick;
        check("rst_wren", 32'(wren0), 0);
        check("rst_awr", 32'(awr0), 0);
        check("rst_din", din0, 0);
        check("rst_done", 32'(done0), 0);
        check("rst_cnt", 32'(cnt0), 0);
        check("rst1_a_ready", 32'(a1_ready), 0);
        check("rst1_done", 32'(done1), 0);
        for (int i = 1; i <= 31; i++) q0.push_back({5'(i), 32'h0});
        a0_valid = 1'b1; a0_adr = 5'd5; a0_data = 32'hDEADBEEF;
        rst0_n = 1'b1;
        #1;
        for (int i = 1; i <= 31; i++) begin
            check("clr_a_ready", 32'(a0_ready), 0);
            check("clr_done", 32'(done0), 0);
            check("clr_cnt", 32'(cnt0), 0);
            tick;
        end
        check("run_a_ready", 32'(a0_ready), 1);
        check("run_b_ready", 32'(b0_ready), 0);
        check("pre_done", 32'(done0), 0);
        q0.push_back({5'd5, 32'hDEADBEEF});
        tick;
        a0_valid = 1'b0;
        b0_valid = 1'b1; b0_adr = 5'd0; b0_data = 32'h1234;
        check("done", 32'(done0), 1);
        check("cnt_before_a", 32'(cnt0), 0);
        #1;
        check("r0_b_ready", 32'(b0_ready), 1);
        check("r0_a_ready", 32'(a0_ready), 0);
        tick;
        b0_valid = 1'b0;
        check("cnt_after_a", 32'(cnt0), 1);
        check("r0_wren", 32'(wren0), 0);
        tick;
        check("r0_cnt", 32'(cnt0), 1);
        a0_valid = 1'b1; a0_adr = 5'd3; a0_data = 32'hA0000000;
        b0_valid = 1'b1; b0_adr = 5'd7; b0_data = 32'hB0000000;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("arb_a_ready", 32'(a0_ready), 32'(grant_a[k]));
            check("arb_b_ready", 32'(b0_ready), 32'(!grant_a[k]));
            q0.push_back(k == 0 ? {5'd3, 32'hA0000000} : k == 1 ? {5'd7, 32'hB0000000} :
                         k == 2 ? {5'd3, 32'hA0000001} : {5'd7, 32'hB0000001});
            tick;
            if (grant_a[k]) a0_data = a0_data + 32'd1;
            else b0_data = b0_data + 32'd1;
            #1;
        end
        a0_valid = 1'b0; b0_valid = 1'b0;
        tick;
        check("arb_cnt", 32'(cnt0), 5);
        a0_valid = 1'b1; a0_adr = 5'd9; a0_data = 32'h00000099;
        #1;
        check("mid_a_ready", 32'(a0_ready), 1);
        tick;
        a0_valid = 1'b0;
        b0_valid = 1'b1;
        rst0_n = 1'b0;
        #1;
        check("mid_wren", 32'(wren0), 0);
        check("mid_done", 32'(done0), 0);
        check("mid_cnt", 32'(cnt0), 0);
        check("mid_b_ready", 32'(b0_ready), 0);
        b0_valid = 1'b0;
        tick;
        for (int i = 1; i <= 31; i++) q0.push_back({5'(i), 32'h0});
        rst0_n = 1'b1;
        #1;
        for (int i = 1; i <= 31; i++) tick;
        check("reclr_done_low", 32'(done0), 0);
        tick;
        check("reclr_done", 32'(done0), 1);
        check("reclr_cnt", 32'(cnt0), 0);
        rst1_n = 1'b1;
        #1;
        check("nc_a_ready", 32'(a1_ready), 1);
        check("nc_done_low", 32'(done1), 0);
        q1.push_back({5'd12, 32'hCAFEF00D});
        tick;
        a1_valid = 1'b0;
        check("nc_done", 32'(done1), 1);
        check("nc_cnt0", 32'(cnt1), 0);
        tick;
        check("nc_cnt1", 32'(cnt1), 1);
        check("nc_wren_off", 32'(wren1), 0);
        tick;
        check("q0_empty", 32'(q0.size()), 0);
        check("q1_empty", 32'(q1.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
